// File: rtl/if_instr_queue_pkg.sv
// Shared types for the fetch-side instruction queue: pipeline exception
// flags, branch-predictor result and the queued entry layout.
package if_instr_queue_pkg;

  localparam int IFQ_DEPTH = 8;

  // Fetch-stage exception flags carried alongside each instruction.
  typedef struct packed {
    logic interrupt;
    logic addr_err_if;
    logic tlb_refill_if;
    logic tlb_invalid_if;
  } ExceptinPipeType;

  // Branch predictor result attached to the fetched instruction.
  typedef struct packed {
    logic [31:0] target;
    logic        is_branch;
    logic        taken;
  } PResult;

  // One queue slot.
  typedef struct packed {
    logic [31:0]     instr;
    logic [31:0]     pc;
    ExceptinPipeType except_type;
    PResult          presult;
  } IFQEntry;

endpackage

// File: rtl/if_instr_queue_storage.sv
// Entry storage for the instruction queue: one synchronous write port,
// one asynchronous read port. Data is not reset; validity is tracked by
// the occupancy counter in the parent.
module if_instr_queue_storage
  import if_instr_queue_pkg::*;
#(
  parameter int DEPTH = IFQ_DEPTH,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [PTR_W-1:0] wr_addr,
  input  IFQEntry          wr_data,
  input  logic [PTR_W-1:0] rd_addr,
  output IFQEntry          rd_data
);

  IFQEntry mem_r [DEPTH];

  // Capture the offered entry into the addressed slot.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/if_instr_queue.sv
// Fetch-side instruction queue. Buffers fetched entries and presents the
// oldest one to the ID register; supports full flush and a branch-redirect
// flush that keeps the delay slot.
module if_instr_queue
  import if_instr_queue_pkg::*;
#(
  parameter int DEPTH = IFQ_DEPTH,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              IF_Flush,
  input  logic              IF_FlushKeepDS,
  input  logic              Fetch_Valid,
  output logic              Fetch_Ready,
  input  logic [31:0]       Fetch_Instr,
  input  logic [31:0]       Fetch_PC,
  input  ExceptinPipeType   Fetch_ExceptType,
  input  PResult            Fetch_PResult,
  input  logic              ID_Wr,
  output logic [31:0]       IF_Instr,
  output logic [31:0]       IF_PC,
  output ExceptinPipeType   IF_ExceptType,
  output PResult            IF_PResult,
  output logic              IF_Valid,
  output logic [CNT_W-1:0]  IFQ_Count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [PTR_W-1:0] head_r, tail_r, head_s, tail_s;
  logic [CNT_W-1:0] count_r, count_s;
  logic             ds_pending_r, ds_pending_s;
  logic             wr_en_s, enq_s, deq_s;
  IFQEntry          wr_data_s, rd_data_s;

  // Ready depends only on the registered count so fetch never sees ID_Wr.
  assign Fetch_Ready = (count_r != FULL_CNT);
  assign IF_Valid    = (count_r != {CNT_W{1'b0}});
  assign IFQ_Count   = count_r;
  assign enq_s       = Fetch_Valid && Fetch_Ready;
  assign deq_s       = ID_Wr && IF_Valid;
  assign wr_data_s   = '{instr: Fetch_Instr, pc: Fetch_PC,
                         except_type: Fetch_ExceptType, presult: Fetch_PResult};

  if_instr_queue_storage #(.DEPTH(DEPTH)) u_storage (
    .clk     (clk),
    .wr_en   (wr_en_s),
    .wr_addr (tail_r),
    .wr_data (wr_data_s),
    .rd_addr (head_r),
    .rd_data (rd_data_s)
  );

  // Next-state for pointers/count: flush beats keep-DS beats normal traffic.
  always_comb begin
    head_s       = head_r;
    tail_s       = tail_r;
    count_s      = count_r;
    ds_pending_s = ds_pending_r;
    wr_en_s      = 1'b0;
    if (IF_Flush) begin
      head_s       = tail_r;
      count_s      = {CNT_W{1'b0}};
      ds_pending_s = 1'b0;
    end else if (IF_FlushKeepDS) begin
      if (count_r > CNT_W'(deq_s)) begin
        // Delay slot already queued: keep only the entry after any pop.
        head_s       = head_r + PTR_W'(deq_s);
        tail_s       = head_r + PTR_W'(deq_s) + PTR_W'(1);
        count_s      = CNT_W'(1);
        ds_pending_s = 1'b0;
      end else if (enq_s) begin
        // Delay slot arrives this very cycle: it becomes the sole entry.
        wr_en_s      = 1'b1;
        head_s       = tail_r;
        tail_s       = tail_r + PTR_W'(1);
        count_s      = CNT_W'(1);
        ds_pending_s = 1'b0;
      end else begin
        // Delay slot still in flight: empty and wait for it.
        head_s       = tail_r;
        count_s      = {CNT_W{1'b0}};
        ds_pending_s = 1'b1;
      end
    end else begin
      if (enq_s) begin
        wr_en_s      = 1'b1;
        tail_s       = tail_r + PTR_W'(1);
        ds_pending_s = 1'b0;
      end else begin
        tail_s       = tail_r;
      end
      if (deq_s) begin
        head_s = head_r + PTR_W'(1);
      end else begin
        head_s = head_r;
      end
      count_s = count_r + CNT_W'(enq_s) - CNT_W'(deq_s);
    end
  end

  // Queue control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_r       <= {PTR_W{1'b0}};
      tail_r       <= {PTR_W{1'b0}};
      count_r      <= {CNT_W{1'b0}};
      ds_pending_r <= 1'b0;
    end else begin
      head_r       <= head_s;
      tail_r       <= tail_s;
      count_r      <= count_s;
      ds_pending_r <= ds_pending_s;
    end
  end

  // Present the head entry, forced to zero when empty so no X reaches ID.
  always_comb begin
    if (IF_Valid) begin
      IF_Instr      = rd_data_s.instr;
      IF_PC         = rd_data_s.pc;
      IF_ExceptType = rd_data_s.except_type;
      IF_PResult    = rd_data_s.presult;
    end else begin
      IF_Instr      = 32'h0000_0000;
      IF_PC         = 32'h0000_0000;
      IF_ExceptType = '{default: 1'b0};
      IF_PResult    = '{default: '0};
    end
  end

endmodule

// File: tb/tb_if_instr_queue.sv
// Directed self-checking bench for the fetch instruction queue.
module tb_if_instr_queue;
  import if_instr_queue_pkg::*;

  logic            clk;
  logic            rst;
  logic            IF_Flush;
  logic            IF_FlushKeepDS;
  logic            Fetch_Valid;
  logic            Fetch_Ready;
  logic [31:0]     Fetch_Instr;
  logic [31:0]     Fetch_PC;
  ExceptinPipeType Fetch_ExceptType;
  PResult          Fetch_PResult;
  logic            ID_Wr;
  logic [31:0]     IF_Instr;
  logic [31:0]     IF_PC;
  ExceptinPipeType IF_ExceptType;
  PResult          IF_PResult;
  logic            IF_Valid;
  logic [3:0]      IFQ_Count;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] mq [$];
  logic [31:0] nxt_pc;
  logic        acc;

  if_instr_queue #(.DEPTH(8)) dut (
    .clk(clk), .rst(rst), .IF_Flush(IF_Flush), .IF_FlushKeepDS(IF_FlushKeepDS),
    .Fetch_Valid(Fetch_Valid), .Fetch_Ready(Fetch_Ready), .Fetch_Instr(Fetch_Instr),
    .Fetch_PC(Fetch_PC), .Fetch_ExceptType(Fetch_ExceptType), .Fetch_PResult(Fetch_PResult),
    .ID_Wr(ID_Wr), .IF_Instr(IF_Instr), .IF_PC(IF_PC), .IF_ExceptType(IF_ExceptType),
    .IF_PResult(IF_PResult), .IF_Valid(IF_Valid), .IFQ_Count(IFQ_Count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one entry for a single cycle (instruction word derived from PC).
  task automatic push(input logic [31:0] pc);
    Fetch_Valid = 1'b1;
    Fetch_PC    = pc;
    Fetch_Instr = pc ^ 32'h2400_0000;
    step();
    Fetch_Valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; IF_Flush = 1'b0; IF_FlushKeepDS = 1'b0; Fetch_Valid = 1'b0;
    Fetch_Instr = 32'h0; Fetch_PC = 32'h0; ID_Wr = 1'b0;
    Fetch_ExceptType = 4'b0000; Fetch_PResult = 34'h0;
    step(); step();
    check_eq("rst_valid", IF_Valid, 1'b0);
    check_eq("rst_instr", IF_Instr, 32'h0);
    check_eq("rst_ready", Fetch_Ready, 1'b1);
    check_eq("rst_count", IFQ_Count, 4'd0);
    rst = 1'b0;

    // Fill with 8 entries, first one carries an exception and prediction.
    for (int i = 0; i < 8; i++) begin
      Fetch_ExceptType = (i == 0) ? 4'b0100 : 4'b0000;
      Fetch_PResult    = {32'hBFC0_0040 + 32'(4 * i), 2'b11};
      push(32'hBFC0_0000 + 32'(4 * i));
    end
    Fetch_ExceptType = 4'b0000;
    Fetch_PResult    = 34'h0;
    check_eq("fill_count", IFQ_Count, 4'd8);
    check_eq("fill_ready", Fetch_Ready, 1'b0);
    check_eq("fill_pc", IF_PC, 32'hBFC0_0000);
    check_eq("fill_instr", IF_Instr, 32'h9BC0_0000);
    check_eq("fill_exc", IF_ExceptType, 4'b0100);
    check_eq("fill_pres", IF_PResult, {32'hBFC0_0040, 2'b11});
    push(32'hDEAD_0000);
    check_eq("full_drop_count", IFQ_Count, 4'd8);
    check_eq("full_drop_pc", IF_PC, 32'hBFC0_0000);

    // Drain across pointer wrap while refilling; 10 pops in exact order.
    for (int i = 0; i < 8; i++) mq.push_back(32'hBFC0_0000 + 32'(4 * i));
    nxt_pc = 32'h8000_0000;
    ID_Wr  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      Fetch_Valid = 1'b1;
      Fetch_PC    = nxt_pc;
      Fetch_Instr = nxt_pc;
      check_eq("wrap_pc", IF_PC, mq[0]);
      acc = (mq.size() != 8);
      check_eq("wrap_ready", Fetch_Ready, acc);
      void'(mq.pop_front());
      if (acc) begin
        mq.push_back(nxt_pc);
        nxt_pc = nxt_pc + 32'h4;
      end
      step();
    end
    Fetch_Valid = 1'b0;
    check_eq("wrap_count", IFQ_Count, 4'd7);
    check_eq("wrap_head", IF_PC, 32'h8000_0008);
    for (int i = 0; i < 7; i++) begin
      check_eq("drain_pc", IF_PC, mq[0]);
      void'(mq.pop_front());
      step();
    end
    check_eq("drain_valid", IF_Valid, 1'b0);
    step();
    check_eq("empty_pop_count", IFQ_Count, 4'd0);
    check_eq("empty_pop_pc", IF_PC, 32'h0);
    ID_Wr = 1'b0;

    // Keep DS with pop: {0x100,0x104,0x108} -> only 0x104 remains.
    push(32'h100); push(32'h104); push(32'h108);
    ID_Wr = 1'b1; IF_FlushKeepDS = 1'b1;
    step();
    ID_Wr = 1'b0; IF_FlushKeepDS = 1'b0;
    check_eq("keepds_count", IFQ_Count, 4'd1);
    check_eq("keepds_pc", IF_PC, 32'h104);
    check_eq("keepds_instr", IF_Instr, 32'h2400_0104);
    ID_Wr = 1'b1; step(); ID_Wr = 1'b0;
    check_eq("keepds_empty", IF_Valid, 1'b0);

    // Keep DS without pop, same-cycle enqueue discarded.
    push(32'h400); push(32'h404);
    IF_FlushKeepDS = 1'b1;
    push(32'h408);
    IF_FlushKeepDS = 1'b0;
    check_eq("keepds_np_count", IFQ_Count, 4'd1);
    check_eq("keepds_np_pc", IF_PC, 32'h400);
    ID_Wr = 1'b1; step(); ID_Wr = 1'b0;

    // DS in flight: empty queue, then 0x204 and 0x300 both stored.
    IF_FlushKeepDS = 1'b1; step(); IF_FlushKeepDS = 1'b0;
    check_eq("dsif_empty", IFQ_Count, 4'd0);
    push(32'h204);
    check_eq("dsif_ds_count", IFQ_Count, 4'd1);
    check_eq("dsif_ds_pc", IF_PC, 32'h204);
    push(32'h300);
    check_eq("dsif_next_count", IFQ_Count, 4'd2);
    ID_Wr = 1'b1; step();
    check_eq("dsif_order", IF_PC, 32'h300);
    step(); ID_Wr = 1'b0;
    check_eq("dsif_drained", IF_Valid, 1'b0);

    // DS arriving in the flush cycle itself becomes the survivor.
    IF_FlushKeepDS = 1'b1; push(32'h500); IF_FlushKeepDS = 1'b0;
    check_eq("dssame_count", IFQ_Count, 4'd1);
    check_eq("dssame_pc", IF_PC, 32'h500);

    // Flush priority over keep-DS and fetch, with 3 entries queued.
    push(32'h504); push(32'h508);
    check_eq("pre_flush_count", IFQ_Count, 4'd3);
    IF_Flush = 1'b1; IF_FlushKeepDS = 1'b1;
    push(32'h600);
    IF_Flush = 1'b0; IF_FlushKeepDS = 1'b0;
    check_eq("flush_count", IFQ_Count, 4'd0);
    check_eq("flush_valid", IF_Valid, 1'b0);
    check_eq("flush_pc", IF_PC, 32'h0);
    check_eq("flush_ready", Fetch_Ready, 1'b1);
    step();
    check_eq("flush_dropped", IFQ_Count, 4'd0);
    push(32'h700);
    check_eq("post_flush_pc", IF_PC, 32'h700);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
